touch_panel_scan_ctrl: RTL and testbench
========================================

TOUCH_PANEL_SCAN_CTRL -- requirements
Module: touch_panel_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 25, clk cycles per SCLK half-period (SCLK = clk/(2*CLK_DIV)); legal range 2..255.
REQ-002 Parameter SCAN_PERIOD, default 500000, clk cycles between scan starts while the pen is held.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 address  in  2  Avalon-MM word address.
REQ-006 chipselect, write_n  in  1 each  Avalon-MM select and active-low write strobe.
REQ-007 writedata  in  32  Avalon-MM write data.
REQ-008 readdata  out  32  Avalon-MM read data, registered, one-cycle latency, unused bits zero.
REQ-009 irq  out  1  sample-ready interrupt.
REQ-010 pen_irq_n  in  1  asynchronous pen-down from the touch ADC, active-low.
REQ-011 spi_cs_n, spi_sclk, spi_mosi  out  1 each  ADC serial port; spi_miso  in  1.

Function
REQ-012 pen_irq_n SHALL pass through a 2-flop synchronizer; pen_down = NOT synchronized value.
REQ-013 Register map: 0 CTRL (R: bit0 enable, bit1 busy, bit2 pen_down; W: bit0 enable); 1 X (R: bits 11:0); 2 Y (R: bits 11:0); 3 STAT (R: bit0 ready, bit1 irq_mask; W: bit1 -> irq_mask, bit0=1 clears ready). Writes to 1/2 SHALL be ignored.
REQ-014 FSM states IDLE, START, FRAME, GAP, UPDATE, WAIT.
REQ-015 IDLE -> START when enable=1 and pen_down=1; START asserts spi_cs_n=0 one CLK_DIV interval before first SCLK edge.
REQ-016 FRAME: 24 SCLK periods, SCLK idle low; mosi changes on falling edge, MSB first, frame bits = {cmd, 16'h0000}; miso sampled on each rising edge into a 24-bit shift register; result = rx[14:3].
REQ-017 Conversion order: cmd 8'hD0 (X) then cmd 8'h90 (Y); GAP deasserts spi_cs_n for exactly CLK_DIV clk cycles between frames and after the last frame.
REQ-018 UPDATE (one cycle): if pen_down sampled 1 at end of both frames, X and Y registers load together and ready sets; otherwise results discarded, registers and ready unchanged.
REQ-019 WAIT: counter runs from scan start; at SCAN_PERIOD cycles -> START if enable=1 and pen_down=1, else IDLE.
REQ-020 busy = 1 in every state except IDLE and WAIT.
REQ-021 Pen release or enable cleared mid-frame SHALL NOT abort the frame; the sequence completes, then REQ-018/019 apply.
REQ-022 irq = ready AND irq_mask, combinational from registers.
REQ-023 ready set (UPDATE) and ready clear (STAT write) in the same cycle: set wins.
REQ-024 A new UPDATE while ready=1 overwrites X/Y; ready stays 1.

Reset
REQ-025 On reset: FSM IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, readdata=0, irq=0, enable=0, irq_mask=0, ready=0, X=Y=0, synchronizer flops=1, counters 0.
REQ-026 Reset mid-frame SHALL take effect the next clk edge with no further SCLK edges.

Configuration
REQ-027 Macro TOUCH_SCAN_AVG_EN defined: each coordinate = (sum of 4 consecutive frames) >> 2, 8 frames per scan (4 X then 4 Y, GAP between each); discard rule of REQ-018 covers all 8.
REQ-028 Macro undefined: one frame per coordinate per REQ-017; no accumulator logic synthesized.

Verification
REQ-029 Enable=1, pen low, ADC model returns X=12'hA5C, Y=12'h3F1 -> X reads 0x00000A5C, Y 0x000003F1, ready=1 after exactly 2 frames.
REQ-030 irq_mask=1, scan completes -> irq=1; write STAT=0x3 -> irq=0 next cycle; write colliding with UPDATE -> ready stays 1.
REQ-031 Pen released during Y frame -> frame completes, X/Y keep prior values, ready unchanged, FSM -> WAIT then IDLE.
REQ-032 CLK_DIV=2, SCAN_PERIOD=200, pen held -> scans start every 200 cycles; 24 SCLK rising edges per frame; mosi bytes 0xD0 then 0x90.
REQ-033 Reset asserted mid-frame -> next cycle spi_cs_n=1, spi_sclk=0, all registers reset values.
REQ-034 TOUCH_SCAN_AVG_EN, X samples 100,101,102,103 -> X reads 101.

Source files
------------

// File: rtl/touch_panel_scan_ctrl_if.sv
// Avalon-MM slave bus of the touch panel scan controller, with its interrupt.
//
// Handshake: there are no wait states. A cycle with chipselect=1 and
// write_n=0 is a write of writedata to address. A cycle with chipselect=1
// and write_n=1 is a read, and readdata for that address is valid on the
// following cycle (zero when chipselect was low). irq is a level that stays
// high while the ready flag is set and unmasked.
interface touch_panel_scan_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/touch_panel_scan_ctrl.sv
// Touch panel scan controller: while the pen is held and scanning is
// enabled, runs an X then a Y conversion on a 24-clock SPI touch ADC every
// SCAN_PERIOD clocks and publishes the coordinates through Avalon-MM
// registers (0 CTRL, 1 X, 2 Y, 3 STAT).
//
// Optional build macro TOUCH_SCAN_AVG_EN: each coordinate is the mean of
// four consecutive conversions (8 frames per scan). Without it, one frame
// per coordinate and no accumulators exist.
//
// scan_state exposes the FSM encoding:
// 0 IDLE, 1 START, 2 FRAME, 3 GAP, 4 UPDATE, 5 WAIT.
module touch_panel_scan_ctrl #(
    parameter int CLK_DIV     = 25,
    parameter int SCAN_PERIOD = 500000
) (
    input  logic                          clk,
    input  logic                          reset,
    touch_panel_scan_ctrl_if.slave        bus,
    input  logic                          pen_irq_n,
    output logic                          spi_cs_n,
    output logic                          spi_sclk,
    output logic                          spi_mosi,
    input  logic                          spi_miso,
    output logic [2:0]                    scan_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_FRAME  = 3'd2,
        ST_GAP    = 3'd3,
        ST_UPDATE = 3'd4,
        ST_WAIT   = 3'd5
    } state_t;

`ifdef TOUCH_SCAN_AVG_EN
    localparam logic [2:0] X_LAST     = 3'd3;
    localparam logic [2:0] LAST_FRAME = 3'd7;
`else
    localparam logic [2:0] X_LAST     = 3'd0;
    localparam logic [2:0] LAST_FRAME = 3'd1;
`endif

    localparam logic [7:0]     DIV_LAST  = 8'(CLK_DIV - 1);
    localparam int             SCW       = $clog2(SCAN_PERIOD) + 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_PERIOD - 1);

    state_t         state;
    logic [7:0]     div_cnt;
    logic [5:0]     half_cnt;
    logic [2:0]     frame_cnt;
    logic [SCW-1:0] scan_cnt;
    logic [23:0]    tx_sr;
    logic [23:0]    rx_sr;
    logic           pen_ok;

    logic           pen_meta;
    logic           pen_sync;
    logic           pen_down;

    logic           enable;
    logic           irq_mask;
    logic           ready;
    logic [11:0]    x_reg;
    logic [11:0]    y_reg;

    logic           div_tick;
    logic           busy;
    logic           scan_go;
    logic           update_ok;
    logic           bus_wr;
    logic [7:0]     cur_cmd;
    logic [11:0]    frame_result;
    logic [11:0]    x_final;
    logic [11:0]    y_final;

`ifdef TOUCH_SCAN_AVG_EN
    logic [13:0]    acc_x;
    logic [13:0]    acc_y;
    assign x_final = acc_x[13:2];
    assign y_final = acc_y[13:2];
`else
    logic [11:0]    x_new;
    logic [11:0]    y_new;
    assign x_final = x_new;
    assign y_final = y_new;
`endif

    assign pen_down     = ~pen_sync;
    assign div_tick     = (div_cnt == DIV_LAST);
    assign busy         = (state != ST_IDLE) && (state != ST_WAIT);
    assign cur_cmd      = (frame_cnt <= X_LAST) ? 8'hD0 : 8'h90;
    assign frame_result = rx_sr[14:3];
    assign update_ok    = (state == ST_UPDATE) && pen_ok;
    assign bus_wr       = bus.chipselect && !bus.write_n;
    assign scan_go      = enable && pen_down &&
                          ((state == ST_IDLE) ||
                           ((state == ST_WAIT) && (scan_cnt == SCAN_LAST)));
    assign scan_state   = state;
    assign bus.irq      = ready & irq_mask;

    // Bits of the bus and shift registers that carry nothing we keep.
    logic unused_bits;
    assign unused_bits = ^{bus.writedata[31:2], rx_sr[23:15], rx_sr[2:0], tx_sr[23]};

    // Two-flop synchronizer for the asynchronous pen-down line (idles high).
    always_ff @(posedge clk) begin
        if (reset) begin
            pen_meta <= 1'b1;
            pen_sync <= 1'b1;
        end else begin
            pen_meta <= pen_irq_n;
            pen_sync <= pen_meta;
        end
    end

    // Scan sequencer: frame timing, SPI shifting and per-frame results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            div_cnt   <= 8'd0;
            half_cnt  <= 6'd0;
            frame_cnt <= 3'd0;
            scan_cnt  <= '0;
            tx_sr     <= 24'd0;
            rx_sr     <= 24'd0;
            pen_ok    <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
`ifdef TOUCH_SCAN_AVG_EN
            acc_x     <= 14'd0;
            acc_y     <= 14'd0;
`else
            x_new     <= 12'd0;
            y_new     <= 12'd0;
`endif
        end else begin
            // Scan period is measured from scan start and saturates, so a
            // scan longer than the period just restarts as soon as it ends.
            if (scan_cnt != SCAN_LAST) begin
                scan_cnt <= scan_cnt + SCW'(1);
            end

            case (state)
                ST_IDLE: begin
                end

                ST_START: begin
                    // chip select is already low; present the first command bit
                    if (div_cnt == 8'd0) begin
                        tx_sr    <= {cur_cmd, 16'h0000};
                        spi_mosi <= cur_cmd[7];
                    end
                    if (div_tick) begin
                        div_cnt  <= 8'd0;
                        spi_sclk <= 1'b1;
                        rx_sr    <= {rx_sr[22:0], spi_miso};
                        half_cnt <= 6'd1;
                        state    <= ST_FRAME;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                ST_FRAME: begin
                    if (div_tick) begin
                        div_cnt <= 8'd0;
                        if (spi_sclk) begin
                            spi_sclk <= 1'b0;
                            if (half_cnt == 6'd47) begin
                                // 24th falling edge closes the frame
                                spi_cs_n <= 1'b1;
                                spi_mosi <= 1'b0;
                                pen_ok   <= pen_ok & pen_down;
                                state    <= ST_GAP;
`ifdef TOUCH_SCAN_AVG_EN
                                if (frame_cnt <= X_LAST) begin
                                    acc_x <= acc_x + {2'b00, frame_result};
                                end else begin
                                    acc_y <= acc_y + {2'b00, frame_result};
                                end
`else
                                if (frame_cnt == 3'd0) begin
                                    x_new <= frame_result;
                                end else begin
                                    y_new <= frame_result;
                                end
`endif
                            end else begin
                                tx_sr    <= {tx_sr[22:0], 1'b0};
                                spi_mosi <= tx_sr[22];
                            end
                        end else begin
                            spi_sclk <= 1'b1;
                            rx_sr    <= {rx_sr[22:0], spi_miso};
                        end
                        half_cnt <= half_cnt + 6'd1;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                ST_GAP: begin
                    if (div_tick) begin
                        div_cnt <= 8'd0;
                        if (frame_cnt == LAST_FRAME) begin
                            state <= ST_UPDATE;
                        end else begin
                            frame_cnt <= frame_cnt + 3'd1;
                            spi_cs_n  <= 1'b0;
                            state     <= ST_START;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                ST_UPDATE: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (scan_cnt == SCAN_LAST) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // New scan from IDLE, or from WAIT once the period has elapsed.
            if (scan_go) begin
                state     <= ST_START;
                spi_cs_n  <= 1'b0;
                div_cnt   <= 8'd0;
                scan_cnt  <= '0;
                frame_cnt <= 3'd0;
                pen_ok    <= 1'b1;
`ifdef TOUCH_SCAN_AVG_EN
                acc_x     <= 14'd0;
                acc_y     <= 14'd0;
`endif
            end
        end
    end

    // Control/status registers; a ready set from UPDATE beats a clear write.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            irq_mask <= 1'b0;
            ready    <= 1'b0;
            x_reg    <= 12'd0;
            y_reg    <= 12'd0;
        end else begin
            if (bus_wr && (bus.address == 2'd0)) begin
                enable <= bus.writedata[0];
            end
            if (bus_wr && (bus.address == 2'd3)) begin
                irq_mask <= bus.writedata[1];
                if (bus.writedata[0]) begin
                    ready <= 1'b0;
                end
            end
            if (update_ok) begin
                ready <= 1'b1;
                x_reg <= x_final;
                y_reg <= y_final;
            end
        end
    end

    // Registered read data, one cycle after the addressed access.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= 32'd0;
        end else if (bus.chipselect) begin
            case (bus.address)
                2'd0:    bus.readdata <= {29'd0, pen_down, busy, enable};
                2'd1:    bus.readdata <= {20'd0, x_reg};
                2'd2:    bus.readdata <= {20'd0, y_reg};
                default: bus.readdata <= {30'd0, irq_mask, ready};
            endcase
        end else begin
            bus.readdata <= 32'd0;
        end
    end

endmodule

// File: tb/tb_touch_panel_scan_ctrl.sv
// Directed bench for touch_panel_scan_ctrl with CLK_DIV=2, SCAN_PERIOD=200.
// An ADC model answers each frame from the captured command byte; a queue
// holds the command sequence each frame must carry.
module tb_touch_panel_scan_ctrl;

    localparam int CLK_DIV     = 2;
    localparam int SCAN_PERIOD = 200;
`ifdef TOUCH_SCAN_AVG_EN
    localparam int NF = 8;
`else
    localparam int NF = 2;
`endif

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FRAME  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_X    = 2'd1;
    localparam logic [1:0] A_Y    = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       pen_irq_n;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [2:0] scan_state;

    touch_panel_scan_ctrl_if bus_if ();

    touch_panel_scan_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .SCAN_PERIOD (SCAN_PERIOD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if.slave),
        .pen_irq_n  (pen_irq_n),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .scan_state (scan_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks (called at a falling clk edge) ----------------
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus_if.address    = addr;
        bus_if.writedata  = data;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus_if.address    = addr;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        data = bus_if.readdata;
    endtask

    task automatic read_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int max_cyc);
        int n = 0;
        while (scan_state !== st && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, {29'd0, scan_state}, {29'd0, st});
    endtask

    task automatic wait_irq(input string tag, input int max_cyc);
        int n = 0;
        while (bus_if.irq !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, bus_if.irq}, 32'd1);
    endtask

    // ---------------- ADC model and scoreboard ----------------
    logic [7:0]  exp_q[$];
    logic [7:0]  cap_cmd;
    logic [7:0]  exp_cmd;
    logic [23:0] word;
    logic [11:0] x_vals [4];
    logic [11:0] y_val;
    int          xi          = 0;
    int          rise_cnt    = 0;
    int          rises_all   = 0;
    int          frames_done = 0;
    int          fall_cyc    = 0;
    int          xs_q[$];
    bit          model_en    = 1'b0;

    always @(negedge spi_cs_n) begin
        rise_cnt = 0;
        cap_cmd  = 8'h00;
        spi_miso = 1'b0;
        fall_cyc = cyc;
    end

    always @(posedge spi_sclk) begin
        if (rise_cnt < 8) cap_cmd = {cap_cmd[6:0], spi_mosi};
        rise_cnt++;
        rises_all++;
    end

    // ADC output: {8 idle, busy 0, 12-bit value, 3 zeros}, next bit after each fall
    always @(negedge spi_sclk) begin
        if (spi_cs_n === 1'b0 && rise_cnt < 24) begin
            if (cap_cmd == 8'hD0) word = {9'd0, x_vals[xi % 4], 3'd0};
            else                  word = {9'd0, y_val, 3'd0};
            spi_miso = word[23 - rise_cnt];
        end else begin
            spi_miso = 1'b0;
        end
    end

    always @(posedge spi_cs_n) begin
        if (model_en) begin
            frames_done++;
            check("sclk_rises_per_frame", rise_cnt, 24);
            if (exp_q.size() == 0) begin
                for (int i = 0; i < NF; i++) exp_q.push_back((i < NF / 2) ? 8'hD0 : 8'h90);
            end
            exp_cmd = exp_q.pop_front();
            check("mosi_cmd", {24'd0, cap_cmd}, {24'd0, exp_cmd});
            if (cap_cmd == 8'hD0) begin
                xs_q.push_back(fall_cyc);
                xi++;
            end
        end
    end

    // ---------------- directed sequence ----------------
    logic [11:0] exp_x1;
    int          frames_mark;
    int          rises_mark;

    initial begin
        reset             = 1'b1;
        pen_irq_n         = 1'b1;
        spi_miso          = 1'b0;
        bus_if.address    = 2'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'd0;
        y_val             = 12'h3F1;
`ifdef TOUCH_SCAN_AVG_EN
        x_vals = '{12'd100, 12'd101, 12'd102, 12'd103};
        exp_x1 = 12'd101;
`else
        x_vals = '{12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C};
        exp_x1 = 12'hA5C;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        check("rst_cs_n",     {31'd0, spi_cs_n}, 32'd1);
        check("rst_sclk",     {31'd0, spi_sclk}, 32'd0);
        check("rst_mosi",     {31'd0, spi_mosi}, 32'd0);
        check("rst_irq",      {31'd0, bus_if.irq}, 32'd0);
        check("rst_readdata", bus_if.readdata, 32'd0);
        check("rst_state",    {29'd0, scan_state}, {29'd0, ST_IDLE});
        model_en = 1'b1;
        read_check("rst_ctrl", A_CTRL, 32'h0);
        read_check("rst_x",    A_X,    32'h0);
        read_check("rst_y",    A_Y,    32'h0);
        read_check("rst_stat", A_STAT, 32'h0);

        // writes to X/Y are ignored
        bus_write(A_X, 32'hFFFF_FFFF);
        bus_write(A_Y, 32'h0000_0123);
        read_check("x_write_ignored", A_X, 32'h0);
        read_check("y_write_ignored", A_Y, 32'h0);

        // first scan: mask on, enable, pen down
        bus_write(A_STAT, 32'h2);
        bus_write(A_CTRL, 32'h1);
        frames_done = 0;
        xi          = 0;
        pen_irq_n   = 1'b0;
        wait_irq("irq_after_scan", 4000);
        check("frames_to_ready", frames_done, NF);
        read_check("ctrl_in_wait", A_CTRL, 32'h5);
        read_check("x_scan1",      A_X,    {20'd0, exp_x1});
        read_check("y_scan1",      A_Y,    32'h0000_03F1);
        read_check("stat_scan1",   A_STAT, 32'h3);

        // clear ready with mask kept: irq drops the next cycle
        bus_write(A_STAT, 32'h3);
        check("irq_cleared", {31'd0, bus_if.irq}, 32'd0);
        read_check("stat_cleared", A_STAT, 32'h2);

        // clear colliding with UPDATE: set wins
        wait_state("reach_update", ST_UPDATE, 4000);
        bus_write(A_STAT, 32'h3);
        check("irq_collide", {31'd0, bus_if.irq}, 32'd1);
        read_check("stat_collide", A_STAT, 32'h3);

        // new UPDATE while ready=1 overwrites X/Y, ready stays 1
        x_vals = '{12'h7E5, 12'h7E5, 12'h7E5, 12'h7E5};
        y_val  = 12'h00A;
        wait_state("reach_update2", ST_UPDATE, 4000);
        @(negedge clk);
        read_check("x_overwrite",    A_X,    32'h0000_07E5);
        read_check("y_overwrite",    A_Y,    32'h0000_000A);
        read_check("stat_overwrite", A_STAT, 32'h3);
`ifndef TOUCH_SCAN_AVG_EN
        check("scan_period", xs_q[$] - xs_q[$-1], SCAN_PERIOD);
`endif

        // pen released during the second frame: results discarded
        x_vals = '{12'h123, 12'h123, 12'h123, 12'h123};
        y_val  = 12'h456;
        wait_state("first_frame_done", ST_GAP, 4000);
        wait_state("second_frame", ST_FRAME, 100);
        frames_mark = frames_done;
        pen_irq_n   = 1'b1;
        wait_state("to_wait", ST_WAIT, 4000);
        check("frames_completed", frames_done - frames_mark, NF - 1);
        wait_state("to_idle", ST_IDLE, 400);
        read_check("x_kept",    A_X,    32'h0000_07E5);
        read_check("y_kept",    A_Y,    32'h0000_000A);
        read_check("stat_kept", A_STAT, 32'h3);
        read_check("ctrl_idle", A_CTRL, 32'h1);

        // reset asserted mid-frame
        pen_irq_n = 1'b0;
        wait_state("reset_frame", ST_FRAME, 400);
        repeat (10) @(negedge clk);
        model_en   = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        rises_mark = rises_all;
        check("rstmid_cs_n",  {31'd0, spi_cs_n}, 32'd1);
        check("rstmid_sclk",  {31'd0, spi_sclk}, 32'd0);
        check("rstmid_mosi",  {31'd0, spi_mosi}, 32'd0);
        check("rstmid_state", {29'd0, scan_state}, {29'd0, ST_IDLE});
        check("rstmid_irq",   {31'd0, bus_if.irq}, 32'd0);
        check("rstmid_rdata", bus_if.readdata, 32'd0);
        repeat (4) @(negedge clk);
        check("rstmid_no_sclk", rises_all - rises_mark, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        read_check("rstmid_ctrl", A_CTRL, 32'h4);
        read_check("rstmid_x",    A_X,    32'h0);
        read_check("rstmid_y",    A_Y,    32'h0);
        read_check("rstmid_stat", A_STAT, 32'h0);
        check("rstmid_stays_idle", {29'd0, scan_state}, {29'd0, ST_IDLE});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
